// File: rtl/fanout_tally.sv
// Per-net sink tally over a netlist pin stream, dumped as (net, fanout, high) in ascending net order.
// Latency: N-cycle table clear after start, 1 record/cycle accumulate, 1 cycle per skipped entry on dump.
// Backpressure: in_ready only while accumulating; dump holds each result until out_ready. Option: FANOUT_DRIVER_CHECK_EN.
module fanout_tally #(
    parameter int NET_ID_W  = 8,
    parameter int CNT_W     = 8,
    parameter int HF_THRESH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    output logic                busy,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [NET_ID_W-1:0] in_net_id,
    input  logic                in_is_sink,
    input  logic                in_last,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [NET_ID_W-1:0] out_net_id,
    output logic [CNT_W-1:0]    out_fanout,
    output logic                out_high,
    output logic                done,
    output logic                err_multi_drv
);

    localparam int                N        = 1 << NET_ID_W;
    localparam logic [NET_ID_W-1:0] ADDR_MAX = {NET_ID_W{1'b1}};
    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W:0]    HF_T     = HF_THRESH[CNT_W:0];

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_ACCUM,
        S_DUMP,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [NET_ID_W-1:0] addr_q, addr_d;
    logic                busy_q, busy_d;
    logic                in_ready_q, in_ready_d;
    logic                done_q, done_d;

    logic [CNT_W-1:0]    cnt_q [N];
    logic [N-1:0]        drv_q;

    logic                wr_en;
    logic [NET_ID_W-1:0] wr_addr;
    logic [CNT_W-1:0]    wr_cnt;
    logic                wr_drv;

    logic [CNT_W-1:0]    rd_cnt;
    logic                rd_drv;
    logic                entry_live;
    logic [CNT_W-1:0]    acc_cnt;
    logic                acc_drv;
    logic                dump_vld;

    // Dump port reads the scan address; accumulate port reads the incoming net.
    assign rd_cnt     = cnt_q[addr_q];
    assign rd_drv     = drv_q[addr_q];
    assign entry_live = (rd_cnt != '0) || rd_drv;
    assign acc_cnt    = cnt_q[in_net_id];
    assign acc_drv    = drv_q[in_net_id];
    assign dump_vld   = (state_q == S_DUMP) && entry_live;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wr_en   = 1'b0;
        wr_addr = addr_q;
        wr_cnt  = '0;
        wr_drv  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_CLEAR;
                    addr_d  = '0;
                end
            end
            S_CLEAR: begin
                wr_en   = 1'b1;
                wr_addr = addr_q;
                if (addr_q == ADDR_MAX) begin
                    state_d = S_ACCUM;
                    addr_d  = '0;
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
            S_ACCUM: begin
                if (in_valid) begin
                    wr_en   = 1'b1;
                    wr_addr = in_net_id;
                    wr_cnt  = acc_cnt;
                    wr_drv  = acc_drv;
                    if (in_is_sink) begin
                        wr_cnt = (acc_cnt == CNT_MAX) ? acc_cnt : acc_cnt + 1'b1;
                    end else begin
                        wr_drv = 1'b1;
                    end
                    if (in_last) begin
                        state_d = S_DUMP;
                        addr_d  = '0;
                    end
                end
            end
            S_DUMP: begin
                if (!entry_live || out_ready) begin
                    if (addr_q == ADDR_MAX) begin
                        state_d = S_DONE;
                    end else begin
                        addr_d = addr_q + 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d     = (state_d != S_IDLE);
        in_ready_d = (state_d == S_ACCUM);
        done_d     = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            busy_q     <= 1'b0;
            in_ready_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            busy_q     <= busy_d;
            in_ready_q <= in_ready_d;
            done_q     <= done_d;
        end
    end

    // Table has no reset: every pass clears it before use.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            cnt_q[wr_addr] <= wr_cnt;
            drv_q[wr_addr] <= wr_drv;
        end
    end

    assign busy       = busy_q;
    assign in_ready   = in_ready_q;
    assign done       = done_q;
    assign out_valid  = dump_vld;
    assign out_net_id = dump_vld ? addr_q : '0;
    assign out_fanout = dump_vld ? rd_cnt : '0;
    assign out_high   = dump_vld && ({1'b0, rd_cnt} >= HF_T);

`ifdef FANOUT_DRIVER_CHECK_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q;
        if ((state_q == S_IDLE) && start) begin
            err_d = 1'b0;
        end else if ((state_q == S_ACCUM) && in_valid && !in_is_sink && acc_drv) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_multi_drv = err_q;
`else
    assign err_multi_drv = 1'b0;
`endif

endmodule

// File: tb/tb_fanout_tally.sv
// Randomized self-checking bench for fanout_tally against a per-net count/driver reference model.
module tb_fanout_tally;

    localparam int HF   = 4;
    localparam int CMAX = 255;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       busy;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_net_id;
    logic       in_is_sink;
    logic       in_last;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_net_id;
    logic [7:0] out_fanout;
    logic       out_high;
    logic       done;
    logic       err_multi_drv;

    fanout_tally #(.NET_ID_W(8), .CNT_W(8), .HF_THRESH(HF)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .busy          (busy),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_net_id     (in_net_id),
        .in_is_sink    (in_is_sink),
        .in_last       (in_last),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_net_id    (out_net_id),
        .out_fanout    (out_fanout),
        .out_high      (out_high),
        .done          (done),
        .err_multi_drv (err_multi_drv)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] id;
        logic [7:0] f;
        logic       h;
    } rec_t;

    int   assertions = 0;
    int   failures   = 0;
    int   m_cnt [256];
    bit   m_drv [256];
    rec_t exp_q [$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid   = 1'b0;
        in_net_id  = 8'd0;
        in_is_sink = 1'b0;
        in_last    = 1'b0;
        start      = 1'b0;
        out_ready  = 1'b1;
    endtask

    function automatic void build_expected();
        exp_q.delete();
        for (int i = 0; i < 256; i++) begin
            if (m_cnt[i] > 0 || m_drv[i]) begin
                rec_t r;
                int   f;
                f    = (m_cnt[i] > CMAX) ? CMAX : m_cnt[i];
                r.id = i[7:0];
                r.f  = f[7:0];
                r.h  = (f >= HF);
                exp_q.push_back(r);
            end
        end
    endfunction

    task automatic do_start(output int clear_cycles);
        int k;
        k = 0;
        while (busy !== 1'b0 && k < 2000) begin
            tick();
            k++;
        end
        for (int i = 0; i < 256; i++) begin
            m_cnt[i] = 0;
            m_drv[i] = 1'b0;
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        clear_cycles = 0;
        while (in_ready !== 1'b1 && clear_cycles < 1000) begin
            tick();
            clear_cycles++;
        end
    endtask

    task automatic send_rec(input int id, input bit sink, input bit last);
        in_valid   = 1'b1;
        in_net_id  = id[7:0];
        in_is_sink = sink;
        in_last    = last;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (sink) m_cnt[id]++;
        else      m_drv[id] = 1'b1;
    endtask

    // mode 0: always ready; 1: random ready; 2: hold ready low 5 cycles on first result.
    task automatic run_dump(input int mode, input string tag);
        int         cyc;
        int         low_left;
        bit         seen_done;
        bit         hold;
        logic [7:0] h_id, h_f;
        logic       h_h;
        rec_t       e;
        build_expected();
        cyc       = 0;
        seen_done = 1'b0;
        hold      = 1'b0;
        low_left  = (mode == 2) ? 5 : 0;
        h_id = '0; h_f = '0; h_h = 1'b0;
        while (cyc < 3000) begin
            if (done === 1'b1) begin
                seen_done = 1'b1;
                break;
            end
            in_valid   = $urandom_range(0, 1);
            in_net_id  = 8'($urandom_range(0, 255));
            in_is_sink = 1'b1;
            if (mode == 2 && out_valid === 1'b1 && low_left > 0) begin
                out_ready = 1'b0;
                low_left--;
            end else if (mode == 1) begin
                out_ready = $urandom_range(0, 1);
            end else begin
                out_ready = 1'b1;
            end
            assertions++;
            if (in_ready !== 1'b0) begin
                failures++;
                $display("FAIL %s in_ready_dump: got %b, required 0", tag, in_ready);
            end
            if (hold) begin
                assertions++;
                if (out_valid !== 1'b1 || out_net_id !== h_id || out_fanout !== h_f || out_high !== h_h) begin
                    failures++;
                    $display("FAIL %s hold_stable: got v=%b id=%0d f=%0d h=%b, required v=1 id=%0d f=%0d h=%b",
                             tag, out_valid, out_net_id, out_fanout, out_high, h_id, h_f, h_h);
                end
            end
            hold = 1'b0;
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                assertions++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL %s dump_extra: got id=%0d f=%0d, required no record", tag, out_net_id, out_fanout);
                end else begin
                    e = exp_q.pop_front();
                    if (out_net_id !== e.id || out_fanout !== e.f || out_high !== e.h) begin
                        failures++;
                        $display("FAIL %s dump_rec: got id=%0d f=%0d h=%b, required id=%0d f=%0d h=%b",
                                 tag, out_net_id, out_fanout, out_high, e.id, e.f, e.h);
                    end
                end
            end else if (out_valid === 1'b1) begin
                hold = 1'b1;
                h_id = out_net_id;
                h_f  = out_fanout;
                h_h  = out_high;
            end
            tick();
            cyc++;
        end
        idle_inputs();
        assertions++;
        if (!seen_done) begin
            failures++;
            $display("FAIL %s done_timeout: got no done in %0d cycles, required done pulse", tag, cyc);
        end
        assertions++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s dump_missing: got %0d records unsent, required 0", tag, exp_q.size());
        end
        assertions++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL %s valid_at_done: got %b, required 0", tag, out_valid);
        end
        tick();
        assertions++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL %s after_done: got done=%b busy=%b, required 0 0", tag, done, busy);
        end
    endtask

    task automatic test_reset();
        int cc;
        rst_n = 1'b0;
        idle_inputs();
        repeat (3) tick();
        assertions++;
        if (busy !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0 || done !== 1'b0 ||
            err_multi_drv !== 1'b0 || out_net_id !== 8'd0 || out_fanout !== 8'd0 || out_high !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: got busy=%b rdy=%b ov=%b done=%b err=%b id=%0d f=%0d h=%b, required all 0",
                     busy, in_ready, out_valid, done, err_multi_drv, out_net_id, out_fanout, out_high);
        end
        rst_n = 1'b1;
        tick();
        do_start(cc);
        send_rec(1, 1'b1, 1'b0);
        send_rec(2, 1'b0, 1'b0);
        send_rec(3, 1'b1, 1'b0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        assertions++;
        if (busy !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_midpass: got busy=%b rdy=%b ov=%b, required 0 0 0", busy, in_ready, out_valid);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            assertions++;
            if (out_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL reset_quiet: got ov=%b done=%b busy=%b, required 0 0 0", out_valid, done, busy);
            end
        end
        do_start(cc);
        assertions++;
        if (cc != 256) begin
            failures++;
            $display("FAIL clear_cycles: got %0d, required 256", cc);
        end
        send_rec(9, 1'b1, 1'b1);
        run_dump(0, "reset_fresh");
    endtask

    task automatic test_basic();
        int cc;
        do_start(cc);
        send_rec(5, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) send_rec(5, 1'b1, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        assertions++;
        if (in_ready !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL start_ignored: got rdy=%b busy=%b, required 1 1", in_ready, busy);
        end
        send_rec(9, 1'b1, 1'b1);
        run_dump(0, "basic");
    endtask

    task automatic test_thresh();
        int cc;
        do_start(cc);
        send_rec(0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) send_rec(11, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) send_rec(12, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) send_rec(255, 1'b1, 1'b0);
        send_rec(255, 1'b1, 1'b1);
        run_dump(1, "thresh");
    endtask

    task automatic test_saturate();
        int cc;
        do_start(cc);
        for (int i = 0; i < 300; i++) send_rec(3, 1'b1, i == 299);
        run_dump(0, "saturate");
    endtask

    task automatic test_back_to_back();
        int cc;
        do_start(cc);
        for (int i = 0; i < 10; i++) send_rec(7, 1'b1, i == 9);
        run_dump(0, "b2b");
    endtask

    task automatic test_backpressure();
        int cc;
        do_start(cc);
        send_rec(20, 1'b1, 1'b0);
        send_rec(21, 1'b0, 1'b0);
        send_rec(20, 1'b1, 1'b0);
        send_rec(22, 1'b1, 1'b1);
        run_dump(2, "backpressure");
    endtask

    task automatic test_multi_drv();
        int cc;
        bit exp_err;
`ifdef FANOUT_DRIVER_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        do_start(cc);
        send_rec(2, 1'b0, 1'b0);
        assertions++;
        if (err_multi_drv !== 1'b0) begin
            failures++;
            $display("FAIL err_single_drv: got %b, required 0", err_multi_drv);
        end
        send_rec(2, 1'b0, 1'b0);
        assertions++;
        if (err_multi_drv !== exp_err) begin
            failures++;
            $display("FAIL err_multi_drv: got %b, required %b", err_multi_drv, exp_err);
        end
        send_rec(2, 1'b1, 1'b1);
        run_dump(0, "multi_drv");
        assertions++;
        if (err_multi_drv !== exp_err) begin
            failures++;
            $display("FAIL err_sticky: got %b, required %b", err_multi_drv, exp_err);
        end
        do_start(cc);
        assertions++;
        if (err_multi_drv !== 1'b0) begin
            failures++;
            $display("FAIL err_cleared: got %b, required 0", err_multi_drv);
        end
        send_rec(2, 1'b0, 1'b1);
        run_dump(0, "single_drv");
    endtask

    task automatic test_random();
        int cc;
        int nrec;
        int id;
        for (int p = 0; p < 5; p++) begin
            do_start(cc);
            nrec = $urandom_range(1, 60);
            for (int r = 0; r < nrec; r++) begin
                if ($urandom_range(0, 2) == 0) begin
                    in_valid   = 1'b0;
                    in_net_id  = 8'($urandom_range(0, 255));
                    in_is_sink = 1'b1;
                    tick();
                end
                id = ($urandom_range(0, 3) == 0) ? $urandom_range(248, 255) : $urandom_range(0, 11);
                send_rec(id, $urandom_range(0, 3) != 0, r == nrec - 1);
            end
            run_dump(1, "random");
        end
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        test_reset();
        test_basic();
        test_thresh();
        test_saturate();
        test_back_to_back();
        test_backpressure();
        test_multi_drv();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule

// File: doc/fanout_tally.md
Name: fanout_tally

Overview:
- Hardware fanout accumulator for the partitioning flow.
- Sits directly downstream of the netlist connection extractor, which emits one record per instance pin connection (net ID, sink/driver flag).
- Tallies sink count per net, then streams out one (net, fanout, high-fanout flag) record per touched net in ascending net-ID order.
- Output feeds the partition cost stage.

Parameters:
- NET_ID_W, 8, net ID width; table depth N = 2**NET_ID_W.
- CNT_W, 8, fanout counter width; saturates at 2**CNT_W-1.
- HF_THRESH, 4, out_high asserted when fanout >= HF_THRESH.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  one-cycle pulse; begins a pass when in IDLE; ignored otherwise.
- busy  out  1  high in every state except IDLE.
- in_valid  in  1  connection record valid.
- in_ready  out  1  high only in ACCUM.
- in_net_id  in  NET_ID_W  net of this pin connection.
- in_is_sink  in  1  1 = load pin (counts toward fanout); 0 = driver pin.
- in_last  in  1  final record of the netlist.
- out_valid  out  1  result record valid.
- out_ready  in  1  downstream accepts result.
- out_net_id  out  NET_ID_W  net ID of result.
- out_fanout  out  CNT_W  saturated sink count.
- out_high  out  1  out_fanout >= HF_THRESH.
- done  out  1  one-cycle pulse after the last result is accepted.
- err_multi_drv  out  1  sticky multi-driver flag; see Optional Feature.

Behaviour:
- Reset (rst_n=0 at an edge):
  - FSM goes to IDLE.
  - All outputs 0, except in_ready=0 and busy=0.
  - Table contents are don't-care; CLEAR always precedes use.
  - Reset mid-pass aborts the pass immediately; no partial output.
- Storage: per net, cnt[CNT_W] plus drv bit; register array, combinational read.
- States:
  - IDLE: start=1 -> CLEAR with addr=0.
  - CLEAR: writes cnt=0, drv=0 at addr, one entry per cycle; after addr N-1 -> ACCUM. Takes exactly N cycles.
  - ACCUM: in_ready=1. On in_valid:
    - in_is_sink=1 -> cnt[id] += 1, saturating at max.
    - in_is_sink=0 -> drv[id]=1.
    - The update is visible to a record for the same ID on the next cycle (back-to-back same-ID records count correctly, with no bubbles).
    - If in_last=1 on the same beat, that record is applied, then -> DUMP with addr=0.
  - DUMP: scans addr 0..N-1.
    - Entries with cnt=0 and drv=0 are skipped at one cycle each.
    - Any other entry presents out_valid=1 with out_net_id=addr, out_fanout=cnt, out_high.
    - Fields stay stable until out_ready=1; addr advances on the cycle of transfer.
    - After addr N-1 is skipped or transferred -> DONE.
  - DONE: done=1 for one cycle -> IDLE.
- out_valid is never asserted outside DUMP. in_valid outside ACCUM is ignored.
- A driver-only net emits with out_fanout=0 and out_high=0. This exposes dangling nets.
- start during a pass is ignored. The pass cannot restart without going through IDLE.
- HF_THRESH=0 makes out_high=1 for every emitted record.

Optional Feature:
- Macro: FANOUT_DRIVER_CHECK_EN.
- With the macro defined:
  - A driver record hitting a net with drv already 1 sets err_multi_drv.
  - The flag is sticky until the next start or reset.
  - Accumulation is otherwise unchanged.
- Without the macro: err_multi_drv is tied 0 and the detection logic is absent.

Test Plan:
- Reset in ACCUM after 3 records, then start -> CLEAR runs 256 cycles; a fresh pass emits no stale entries.
- Records (5,drv), (5,sink)x4, (9,sink), last on (9,sink) -> outputs (5,4,high=1), (9,1,high=0); then done pulse; in_ready=0 during DUMP.
- Net 3 receives 300 sinks with CNT_W=8 -> out_fanout=255, out_high=1.
- Same-ID back-to-back: 10 consecutive (7,sink) with in_valid held high -> out_fanout=10.
- out_ready held 0 for 5 cycles on the first result -> out_valid, out_net_id and out_fanout stable; no record lost or duplicated.
- With FANOUT_DRIVER_CHECK_EN: (2,drv) twice -> err_multi_drv=1 from the cycle after the second driver, until the next start. Without the macro -> stays 0.
